// File: rtl/fifo_stream_reader.sv
// Read-side consumer for the synchronous FIFO: issues reads, absorbs the 1-cycle RAM latency, emits a valid/ready stream.
// First word is valid 2 cycles after the first read; a 2-entry head/skid buffer keeps full rate under out_ready and stalls lose nothing.
module fifo_stream_reader #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fifo_empty,
  output logic                 fifo_read_req,
  input  logic [WIDTH-1:0]     fifo_read_data,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] out_count
);

  logic [1:0]       occ;
  logic             inflight;
  logic [WIDTH-1:0] skid_data;
  logic             pop;
  logic [1:0]       occ_after_pop;
  logic [1:0]       committed;

  assign pop           = out_valid && out_ready;
  assign occ_after_pop = occ - {1'b0, pop};

  // Slots already claimed once this cycle's pop and returning word are settled.
  assign committed     = occ_after_pop + {1'b0, inflight};

  assign fifo_read_req = rst_n && !fifo_empty && (committed < 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ       <= 2'd0;
      inflight  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_data <= '0;
      out_count <= '0;
    end else begin
      if (inflight && occ_after_pop == 2'd0) begin
        out_data <= fifo_read_data;
      end else begin
        if (pop && occ == 2'd2) begin
          out_data <= skid_data;
        end
        if (inflight) begin
          skid_data <= fifo_read_data;
        end
      end
      occ       <= committed;
      out_valid <= (committed != 2'd0);
      inflight  <= fifo_read_req;
      if (pop) begin
        out_count <= out_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed and random checks of fifo_stream_reader against a behavioural FIFO with 1-cycle read latency.
module tb_fifo_stream_reader;
  localparam int WIDTH     = 8;
  localparam int CNT_WIDTH = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 fifo_empty;
  logic                 fifo_read_req;
  logic [WIDTH-1:0]     fifo_read_data = '0;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic                 out_ready = 1'b0;
  logic [CNT_WIDTH-1:0] out_count;

  logic [WIDTH-1:0] mem [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pop_ptr = 0;
  int issued = 0;
  int issued_lag = 0;
  int popped = 0;
  int viol_empty = 0;
  int viol_occ = 0;
  int viol_vld = 0;
  int checks = 0;
  int passes = 0;

  fifo_stream_reader #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_read_req(fifo_read_req),
    .fifo_read_data(fifo_read_data), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .out_count(out_count)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  // FIFO read port plus bookkeeping of issued reads and pops
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued     <= 0;
      issued_lag <= 0;
      popped     <= 0;
    end else begin
      if (fifo_read_req) begin
        fifo_read_data <= mem[rd_ptr[11:0]];
        rd_ptr         <= rd_ptr + 1;
      end
      issued_lag <= issued;
      issued     <= issued + (fifo_read_req ? 1 : 0);
      popped     <= popped + ((out_valid && out_ready) ? 1 : 0);
    end
  end

  always @(posedge clk) begin
    if (rst_n && fifo_read_req && fifo_empty) viol_empty <= viol_empty + 1;
  end

  // Buffered words = arrived reads minus pops; must stay 0..2 and agree with out_valid
  always @(negedge clk) begin
    if (rst_n) begin
      if ((issued_lag - popped) > 2 || (issued_lag - popped) < 0) viol_occ <= viol_occ + 1;
      if (out_valid !== (issued_lag != popped)) viol_vld <= viol_vld + 1;
    end
  end

  task automatic push(input logic [WIDTH-1:0] d);
    mem[wr_ptr[11:0]] = d;
    wr_ptr++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    wr_ptr  = rd_ptr;
    pop_ptr = rd_ptr;
  endtask

  task automatic test_reset();
    do_reset();
    push(8'hAA);
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else passes++;
    checks++; if (out_data !== 8'h00) $display("FAIL reset_data got %h want 00", out_data); else passes++;
    checks++; if (out_count !== 4'd0) $display("FAIL reset_count got %0d want 0", out_count); else passes++;
    checks++; if (fifo_read_req !== 1'b0) $display("FAIL reset_req got %b want 0", fifo_read_req); else passes++;
    wr_ptr = rd_ptr;
  endtask

  task automatic test_basic();
    logic             exp_v;
    logic [WIDTH-1:0] exp_d;
    do_reset();
    for (int i = 1; i <= 4; i++) push(WIDTH'(i));
    out_ready = 1'b1;
    rst_n = 1'b1;
    #1;
    checks++; if (fifo_read_req !== 1'b1) $display("FAIL basic_first_req got %b want 1", fifo_read_req); else passes++;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk); #1;
      exp_v = (i >= 2 && i <= 5);
      exp_d = WIDTH'(i - 1);
      checks++;
      if (out_valid !== exp_v || (exp_v && out_data !== exp_d))
        $display("FAIL basic_cycle%0d got v=%b d=%h want v=%b d=%h", i, out_valid, out_data, exp_v, exp_d);
      else passes++;
    end
    checks++; if (out_count !== 4'd4) $display("FAIL basic_count got %0d want 4", out_count); else passes++;
  endtask

  task automatic test_backpressure();
    int nreads;
    do_reset();
    for (int i = 0; i < 6; i++) push(8'h10 + WIDTH'(i));
    out_ready = 1'b0;
    rst_n = 1'b1;
    nreads = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (fifo_read_req) nreads++;
      if (c >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h10)
          $display("FAIL stall_hold c%0d got v=%b d=%h want v=1 d=10", c, out_valid, out_data);
        else passes++;
      end
      @(negedge clk);
    end
    checks++; if (nreads !== 2) $display("FAIL stall_reads got %0d want 2", nreads); else passes++;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h10 + WIDTH'(k))
        $display("FAIL release_word%0d got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, 8'h10 + WIDTH'(k));
      else passes++;
      @(negedge clk);
    end
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL release_drained got %b want 0", out_valid); else passes++;
    checks++; if (out_count !== 4'd6) $display("FAIL release_count got %0d want 6", out_count); else passes++;
  endtask

  task automatic test_coincide();
    do_reset();
    push(8'hA0);
    out_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    push(8'hA1);
    #1;
    checks++; if (fifo_read_req !== 1'b1) $display("FAIL coin_second_req got %b want 1", fifo_read_req); else passes++;
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hA0) $display("FAIL coin_head0 got v=%b d=%h want v=1 d=a0", out_valid, out_data); else passes++;
    checks++; if (fifo_read_req !== 1'b0) $display("FAIL coin_empty_req got %b want 0", fifo_read_req); else passes++;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hA1) $display("FAIL coin_head1 got v=%b d=%h want v=1 d=a1", out_valid, out_data); else passes++;
    checks++; if (out_count !== 4'd1) $display("FAIL coin_count1 got %0d want 1", out_count); else passes++;
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hA1) $display("FAIL coin_hold1 got v=%b d=%h want v=1 d=a1", out_valid, out_data); else passes++;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_count !== 4'd2) $display("FAIL coin_end got v=%b cnt=%0d want v=0 cnt=2", out_valid, out_count); else passes++;
  endtask

  task automatic test_reset_mid();
    int got;
    logic [WIDTH-1:0] exp_d;
    for (int i = 0; i < 5; i++) push(8'h30 + WIDTH'(i));
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h30 || out_count !== 4'd2)
      $display("FAIL mid_prefill got v=%b d=%h cnt=%0d want v=1 d=30 cnt=2", out_valid, out_data, out_count);
    else passes++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_count !== 4'd0 || fifo_read_req !== 1'b0)
      $display("FAIL mid_reset got v=%b d=%h cnt=%0d req=%b want 0/00/0/0", out_valid, out_data, out_count, fifo_read_req);
    else passes++;
    @(negedge clk); #1;
    checks++; if (fifo_read_req !== 1'b0) $display("FAIL mid_reset_req got %b want 0", fifo_read_req); else passes++;
    wr_ptr  = rd_ptr;
    pop_ptr = rd_ptr;
    rst_n = 1'b1;
    push(8'h40);
    push(8'h41);
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (out_valid) begin
        exp_d = 8'h40 + WIDTH'(got);
        checks++;
        if (got >= 2 || out_data !== exp_d) $display("FAIL mid_recover_word%0d got %h want %h", got, out_data, exp_d);
        else passes++;
        got++;
      end
      @(negedge clk);
    end
    checks++; if (got !== 2) $display("FAIL mid_recover_total got %0d want 2", got); else passes++;
  endtask

  task automatic test_random();
    int npush, npop, cyc;
    do_reset();
    rst_n = 1'b1;
    npush = 0; npop = 0; cyc = 0;
    while (npop < 1000 && cyc < 20000) begin
      if (npush < 1000 && $urandom_range(1, 0) == 1) begin
        push(WIDTH'($urandom));
        npush++;
      end
      out_ready = ($urandom_range(1, 0) == 1);
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== mem[pop_ptr[11:0]]) $display("FAIL rand_word%0d got %h want %h", npop, out_data, mem[pop_ptr[11:0]]);
        else passes++;
        pop_ptr++;
        npop++;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    #1;
    checks++; if (npop !== 1000) $display("FAIL rand_total got %0d want 1000", npop); else passes++;
    checks++; if (out_count !== 4'd8) $display("FAIL rand_count got %0d want 8", out_count); else passes++;
    checks++; if (viol_empty !== 0) $display("FAIL read_while_empty got %0d want 0", viol_empty); else passes++;
    checks++; if (viol_occ !== 0) $display("FAIL occupancy_bound got %0d want 0", viol_occ); else passes++;
    checks++; if (viol_vld !== 0) $display("FAIL valid_vs_occupancy got %0d want 0", viol_vld); else passes++;
  endtask

  task automatic test_wrap();
    int npop, cyc;
    logic [CNT_WIDTH-1:0] prev;
    logic wrapped;
    do_reset();
    for (int i = 0; i < 17; i++) push(8'h50 + WIDTH'(i));
    out_ready = 1'b1;
    rst_n = 1'b1;
    npop = 0; cyc = 0; wrapped = 1'b0; prev = '0;
    while (npop < 17 && cyc < 60) begin
      #1;
      checks++;
      if (out_count !== npop[3:0]) $display("FAIL wrap_count_pop%0d got %0d want %0d", npop, out_count, npop[3:0]);
      else passes++;
      if (prev == 4'd15 && out_count == 4'd0) wrapped = 1'b1;
      prev = out_count;
      if (out_valid) begin
        checks++;
        if (out_data !== mem[pop_ptr[11:0]]) $display("FAIL wrap_word%0d got %h want %h", npop, out_data, mem[pop_ptr[11:0]]);
        else passes++;
        pop_ptr++;
        npop++;
      end
      @(negedge clk);
      cyc++;
    end
    #1;
    checks++; if (npop !== 17) $display("FAIL wrap_total got %0d want 17", npop); else passes++;
    checks++; if (wrapped !== 1'b1) $display("FAIL wrap_15_to_0 got %b want 1", wrapped); else passes++;
    checks++; if (out_count !== 4'd1) $display("FAIL wrap_final got %0d want 1", out_count); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_coincide();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
